// File: rtl/sifive_insight_tl_a_prot_responder.sv
// TileLink-UL A-channel responder with AMBA protection checks over a small word store.
// Optional secure upper region enabled by defining SIFIVE_INSIGHT_PROT_SECURE_EN.
module sifive_insight_tl_a_prot_responder #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned SRC_W      = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned EXEC_WORDS = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [2:0]        a_opcode,
  input  logic [1:0]        a_size,
  input  logic [SRC_W-1:0]  a_source,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [3:0]        a_mask,
  input  logic [31:0]       a_data,
  input  logic              a_prot_privileged,
  input  logic              a_prot_secure,
  input  logic              a_prot_fetch,
  input  logic              a_prot_bufferable,
  input  logic              a_prot_modifiable,
  input  logic              a_prot_readalloc,
  input  logic              a_prot_writealloc,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [2:0]        d_opcode,
  output logic [1:0]        d_size,
  output logic [SRC_W-1:0]  d_source,
  output logic [31:0]       d_data,
  output logic              d_denied,
  output logic              d_corrupt,
  output logic [7:0]        viol_count,
  input  logic              viol_clear
);

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned LANES    = 4;
  localparam int unsigned VIOL_W   = 8;
  localparam logic [2:0] OP_PUT_FULL  = 3'd0;
  localparam logic [2:0] OP_PUT_PART  = 3'd1;
  localparam logic [2:0] OP_GET       = 3'd4;
  localparam logic [2:0] OP_ACK       = 3'd0;
  localparam logic [2:0] OP_ACK_DATA  = 3'd1;
  localparam logic [VIOL_W-1:0] VIOL_MAX = '1;

  typedef enum logic {IDLE, RESP} state_t;

  state_t state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0] idx_c;
  logic accept_c, is_get_c, is_put_c, misalign_c, secure_viol_c, denied_c, mem_we_c;

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    case (state)
      IDLE: if (a_valid) begin
        accept_c  = 1'b1;
        state_nxt = RESP;
      end
      RESP: if (d_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request decode and protection evaluation
  always_comb begin
    idx_c    = a_address[IDX_W+1:2];
    is_get_c = (a_opcode == OP_GET);
    is_put_c = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART);
    case (a_size)
      2'd0:    misalign_c = 1'b0;
      2'd1:    misalign_c = a_address[0];
      2'd2:    misalign_c = |a_address[1:0];
      default: misalign_c = 1'b1;
    endcase
`ifdef SIFIVE_INSIGHT_PROT_SECURE_EN
    secure_viol_c = !a_prot_secure && idx_c[IDX_W-1];
`else
    secure_viol_c = 1'b0;
`endif
    denied_c = !(is_get_c || is_put_c)
            || misalign_c
            || ({1'b0, a_address} >= (ADDR_W+1)'(DEPTH * 4))
            || (is_put_c && !a_prot_privileged)
            || (is_get_c && a_prot_fetch && ({1'b0, idx_c} >= (IDX_W+1)'(EXEC_WORDS)))
            || secure_viol_c;
    mem_we_c = accept_c && is_put_c && !denied_c;
  end

  // Registered handshake, response capture and violation counter
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      a_ready    <= 1'b1;
      d_valid    <= 1'b0;
      d_opcode   <= '0;
      d_size     <= '0;
      d_source   <= '0;
      d_data     <= '0;
      d_denied   <= 1'b0;
      d_corrupt  <= 1'b0;
      viol_count <= '0;
    end else begin
      a_ready <= (state_nxt == IDLE);
      d_valid <= (state_nxt == RESP);
      if (accept_c) begin
        d_opcode  <= is_get_c ? OP_ACK_DATA : OP_ACK;
        d_size    <= a_size;
        d_source  <= a_source;
        d_data    <= (is_get_c && !denied_c) ? mem[idx_c] : '0;
        d_denied  <= denied_c;
        d_corrupt <= denied_c && is_get_c;
      end
      if (viol_clear)
        viol_count <= '0;
      else if (accept_c && denied_c && (viol_count != VIOL_MAX))
        viol_count <= viol_count + VIOL_W'(1);
    end
  end

  // Word store with byte-lane writes
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we_c) begin
      for (int b = 0; b < LANES; b++)
        if (a_mask[b]) mem[idx_c][8*b +: 8] <= a_data[8*b +: 8];
    end
  end

  // Cache/buffer hints carry no decision weight here
`ifdef SIFIVE_INSIGHT_PROT_SECURE_EN
  logic unused_prot_c;
  assign unused_prot_c = ^{a_prot_bufferable, a_prot_modifiable, a_prot_readalloc, a_prot_writealloc};
`else
  logic unused_prot_c;
  assign unused_prot_c = ^{a_prot_bufferable, a_prot_modifiable, a_prot_readalloc, a_prot_writealloc,
                           a_prot_secure};
`endif

endmodule

// File: doc/sifive_insight_tl_a_prot_responder.md
# sifive_insight_tl_a_prot_responder

TileLink-UL A-channel responder (manager side) that consumes requests carrying the `amba_prot` user field and returns D-channel responses. It backs a small word-addressed register store and enforces AMBA protection attributes (privileged, fetch, optionally secure) per access. Denied accesses get a TileLink `denied` response and are counted. It is the terminating end of the instruction/data TL port, used as a protection-checking target in Insight bring-up and verification.

## Interface
- `ADDR_W`, 12, A-channel address width
- `SRC_W`, 4, source ID width
- `DEPTH`, 16, number of 32-bit storage words (power of 2, ≥4)
- `EXEC_WORDS`, 8, words `[0, EXEC_WORDS)` permit `fetch=1` reads

Ports:
- `clock` in 1: single clock
- `reset_n` in 1: synchronous, active-low reset
- `a_valid` in 1 / `a_ready` out 1: A handshake
- `a_opcode` in 3: 0 PutFullData, 1 PutPartialData, 4 Get
- `a_size` in 2: log2 bytes
- `a_source` in SRC_W: request source
- `a_address` in ADDR_W: byte address
- `a_mask` in 4 / `a_data` in 32: write mask/data
- `a_prot_privileged`, `a_prot_secure`, `a_prot_fetch`, `a_prot_bufferable`, `a_prot_modifiable`, `a_prot_readalloc`, `a_prot_writealloc` in 1 each: `amba_prot` user bits
- `d_valid` out 1 / `d_ready` in 1: D handshake
- `d_opcode` out 3: 0 AccessAck, 1 AccessAckData
- `d_size` out 2, `d_source` out SRC_W: echoed
- `d_data` out 32, `d_denied` out 1, `d_corrupt` out 1
- `viol_count` out 8: saturating denied-access count
- `viol_clear` in 1: synchronous clear of `viol_count`

## Operation
- FSM states: IDLE, RESP. `a_ready` = (state==IDLE), registered.
- IDLE & `a_valid`: accept, evaluate, capture response fields, go RESP.
- RESP: `d_valid`=1, all `d_*` stable; on `d_ready` return to IDLE.
- Word index = `a_address[log2(DEPTH)+1:2]`. Denied when any of:
  - opcode not in {0,1,4};
  - `a_size` > 2, or `a_address` not `a_size`-aligned;
  - `a_address` ≥ DEPTH*4;
  - Put with `a_prot_privileged`=0;
  - Get with `a_prot_fetch`=1 and index ≥ EXEC_WORDS;
  - (macro) secure rule, see Configuration.
- Allowed Put: byte lanes with `a_mask` bit set written at acceptance edge; `d_opcode`=0.
- Allowed Get: `d_data` = word read at acceptance (pre-write value irrelevant; no same-cycle write); `d_opcode`=1.
- Denied: storage unchanged; `d_denied`=1; `d_opcode` per request class (Get→1, others→0); `d_data`=0; `d_corrupt`=1 only if `d_opcode`=1.
- `bufferable/modifiable/readalloc/writealloc` ignored for decisions.
- `viol_count` +1 on each denied acceptance, saturates at 255; `viol_clear` wins over simultaneous increment (result 0).

## Timing
- Reset (`reset_n`=0 at edge): state IDLE, `a_ready`=1 after reset deasserts, `d_valid`=0, `d_opcode`=0, `d_size`=0, `d_source`=0, `d_data`=0, `d_denied`=0, `d_corrupt`=0, `viol_count`=0, storage all zero.
- Reset during RESP aborts the pending response; it is not replayed.
- Latency: acceptance at edge N → `d_valid` high from N+1.
- `d_ready` held high: one transaction per 2 cycles. `d_ready` low: D holds indefinitely, `a_ready`=0.
- `a_ready` is not combinationally dependent on `d_ready`.

## Configuration
- `SIFIVE_INSIGHT_PROT_SECURE_EN` defined: upper half of storage (index ≥ DEPTH/2) is secure; any access there with `a_prot_secure`=0 is denied.
- Undefined: `a_prot_secure` ignored; no secure region.

## Test plan
- Put 0xDEADBEEF, mask 0xF, addr 0x8, privileged=1 → AccessAck, denied=0; Get 0x8 → AccessAckData 0xDEADBEEF.
- Put addr 0x4 privileged=0 → AccessAck denied=1, word unchanged (Get returns 0), `viol_count`=1.
- Get fetch=1 addr 0x20 (index 8, EXEC_WORDS=8) → AccessAckData, denied=1, corrupt=1, data 0; addr 0x1C → denied=0.
- PutPartial mask 0x3 data 0x11223344 at 0x0 → Get returns 0x00003344; Get size=3 or addr 0x40 → denied.
- Hold `d_ready`=0 5 cycles after a Get → `d_valid`/`d_data` stable, `a_ready`=0; 256 denied accesses → `viol_count`=255; `viol_clear` with simultaneous denial → 0.
- With macro: Get addr 0x20 secure=0 → denied; secure=1 → allowed. Without macro: both allowed.
